// File: rtl/uart_cmd_host.sv
// uart_cmd_host
//   Host-side initiator for the UART command protocol. Accepts one request,
//   sends it as a 6-byte frame "A5 cmd addr d0 d1 chk" on the TX byte stream,
//   then collects the 6-byte reply "5A status addr d0 d1 chk" from the RX byte
//   stream. The reply is checked and reported with an error code. A response
//   timeout bounds the wait.
//
//   Optional feature macro: UART_CMD_HOST_RETRY_EN
//     When defined, a BADSOF / BADCHK / TIMEOUT result causes one resend of
//     the latched frame. The second result is reported with rsp_retried=1.
//     When undefined, every first result is reported and rsp_retried stays 0.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_ready       request handshake (ready only in IDLE, not in reset)
//   req_cmd, req_addr         command and address bytes
//   req_data                  payload, d0=[7:0], d1=[15:8]
//   tx_valid/tx_ready/tx_data TX byte stream
//   rx_valid/rx_data          RX byte stream, one pulse per byte
//   rsp_valid                 one-cycle result pulse
//   rsp_err                   0 OK, 1 BADSOF, 2 BADCHK, 3 ADDRMISMATCH, 4 TIMEOUT
//   rsp_status/addr/data      reply bytes 1, 2 and {4,3}
//   rsp_retried               result came from the resent frame
module uart_cmd_host #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_cmd,
    input  logic [7:0]  req_addr,
    input  logic [15:0] req_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rsp_valid,
    output logic [2:0]  rsp_err,
    output logic [7:0]  rsp_status,
    output logic [7:0]  rsp_addr,
    output logic [15:0] rsp_data,
    output logic        rsp_retried
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SOF_CMD  = 8'hA5;
    localparam logic [7:0] SOF_RSP  = 8'h5A;
    localparam logic [7:0] CMD_PING = 8'h03;

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_BADSOF  = 3'd1;
    localparam logic [2:0] ERR_BADCHK  = 3'd2;
    localparam logic [2:0] ERR_ADDR    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} state_t;

    state_t          state_q;
    logic [5:0][7:0] frame_q;    // latched command frame, [0] = A5
    logic [2:0]      idx_q;      // TX byte index
    logic [2:0]      rx_cnt_q;   // RX bytes captured so far
    logic [4:0][7:0] rxb_q;      // reply bytes 0..4; byte 5 is checked on arrival
    logic [TW-1:0]   tmo_q;
    logic            retried_q;  // current attempt is the resend

    logic            tx_valid_q;
    logic [7:0]      tx_data_q;
    logic            rsp_valid_q;
    logic [2:0]      rsp_err_q;
    logic [7:0]      rsp_status_q;
    logic [7:0]      rsp_addr_q;
    logic [15:0]     rsp_data_q;
    logic            rsp_retried_q;

    logic [7:0]      req_chk_d;
    logic [7:0]      rx_chk_d;
    logic [2:0]      fr_err_d;
    logic            rx_last_d;
    logic            tmo_exp_d;
    logic            done_d;
    logic [2:0]      done_err_d;
    logic            retry_d;

    assign req_ready   = (state_q == S_IDLE) && !rst;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_addr    = rsp_addr_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_retried = rsp_retried_q;

    always_comb begin
        req_chk_d = SOF_CMD ^ req_cmd ^ req_addr ^ req_data[7:0] ^ req_data[15:8];
        rx_chk_d  = rxb_q[0] ^ rxb_q[1] ^ rxb_q[2] ^ rxb_q[3] ^ rxb_q[4];

        // Priority: SOF, then checksum (incoming byte is b5), then address.
        if (rxb_q[0] != SOF_RSP)
            fr_err_d = ERR_BADSOF;
        else if (rx_data != rx_chk_d)
            fr_err_d = ERR_BADCHK;
        else if (frame_q[1] != CMD_PING && rxb_q[2] != frame_q[2])
            fr_err_d = ERR_ADDR;
        else
            fr_err_d = ERR_OK;

        rx_last_d  = (state_q == S_WAIT) && rx_valid && (rx_cnt_q == 3'd5);
        // A completing byte in the expiry cycle wins over the timeout.
        tmo_exp_d  = (state_q == S_WAIT) && (tmo_q == '0) && !rx_last_d;
        done_d     = rx_last_d || tmo_exp_d;
        done_err_d = rx_last_d ? fr_err_d : ERR_TIMEOUT;

`ifdef UART_CMD_HOST_RETRY_EN
        retry_d = done_d && !retried_q &&
                  (done_err_d == ERR_BADSOF || done_err_d == ERR_BADCHK ||
                   done_err_d == ERR_TIMEOUT);
`else
        retry_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            frame_q       <= '0;
            idx_q         <= '0;
            rx_cnt_q      <= '0;
            rxb_q         <= '0;
            tmo_q         <= '0;
            retried_q     <= 1'b0;
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= '0;
            rsp_status_q  <= '0;
            rsp_addr_q    <= '0;
            rsp_data_q    <= '0;
            rsp_retried_q <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        frame_q    <= {req_chk_d, req_data[15:8], req_data[7:0],
                                       req_addr, req_cmd, SOF_CMD};
                        idx_q      <= '0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= SOF_CMD;
                        retried_q  <= 1'b0;
                        state_q    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (tx_ready) begin
                        if (idx_q == 3'd5) begin
                            tx_valid_q <= 1'b0;
                            rx_cnt_q   <= '0;
                            rxb_q      <= '0;
                            tmo_q      <= TW'(TIMEOUT_CYCLES);
                            state_q    <= S_WAIT;
                        end else begin
                            idx_q     <= idx_q + 3'd1;
                            tx_data_q <= frame_q[idx_q + 3'd1];
                        end
                    end
                end
                S_WAIT: begin
                    if (retry_d) begin
                        // Resend the same latched frame from the start.
                        retried_q  <= 1'b1;
                        idx_q      <= '0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= SOF_CMD;
                        state_q    <= S_SEND;
                    end else if (done_d) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_err_q     <= done_err_d;
                        rsp_status_q  <= rxb_q[1];
                        rsp_addr_q    <= rxb_q[2];
                        rsp_data_q    <= {rxb_q[4], rxb_q[3]};
                        rsp_retried_q <= retried_q;
                        state_q       <= S_IDLE;
                    end else begin
                        tmo_q <= (tmo_q == '0) ? '0 : tmo_q - TW'(1);
                        if (rx_valid) begin
                            rxb_q[rx_cnt_q] <= rx_data;
                            rx_cnt_q        <= rx_cnt_q + 3'd1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_host.sv
// Self-checking bench for uart_cmd_host: directed frames from the protocol
// examples plus randomized requests/replies, checked against a byte-level
// reference model of the frame and reply rules.
module tb_uart_cmd_host;

    localparam int T = 16;

`ifdef UART_CMD_HOST_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [7:0]  req_cmd, req_addr;
    logic [15:0] req_data;
    logic        tx_valid, tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rsp_valid;
    logic [2:0]  rsp_err;
    logic [7:0]  rsp_status, rsp_addr;
    logic [15:0] rsp_data;
    logic        rsp_retried;

    int n_cmp = 0;
    int n_err = 0;

    uart_cmd_host #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr), .req_data(req_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_status(rsp_status),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data), .rsp_retried(rsp_retried)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0][7:0] mk(input logic [7:0] b0, b1, b2, b3, b4, b5);
        return {b5, b4, b3, b2, b1, b0};
    endfunction

    // Reference: expected error for a complete reply to (cmd, addr).
    function automatic logic [2:0] ref_err(input logic [7:0] cmd, addr, input logic [5:0][7:0] r);
        if (r[0] != 8'h5A) return 3'd1;
        if (r[5] != (r[0] ^ r[1] ^ r[2] ^ r[3] ^ r[4])) return 3'd2;
        if (cmd != 8'h03 && r[2] != addr) return 3'd3;
        return 3'd0;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_txn(input logic [7:0] cmd, input logic [7:0] addr,
                           input logic [15:0] data, input logic [5:0][7:0] rep,
                           input bit no_rep, input bit stall);
        logic [5:0][7:0] fr;
        logic [2:0] e;
        bit reported;
        int k, lat;
        fr = mk(8'hA5, cmd, addr, data[7:0], data[15:8],
                8'hA5 ^ cmd ^ addr ^ data[7:0] ^ data[15:8]);
        e = no_rep ? 3'd4 : ref_err(cmd, addr, rep);

        // junk RX bytes while idle must be ignored
        repeat ($urandom_range(0, 2)) begin
            rx_valid = 1'b1; rx_data = 8'($urandom); tick();
        end
        rx_valid = 1'b0;

        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_cmd = cmd; req_addr = addr; req_data = data;
        tick();
        req_valid = 1'b0; req_cmd = 8'($urandom); req_addr = 8'($urandom);
        req_data = 16'($urandom);

        reported = 1'b0;
        for (int att = 0; att < 2 && !reported; att++) begin
            k = 0;
            for (int cyc = 0; cyc < 200 && k < 6; cyc++) begin
                tx_ready = stall ? cyc[0] : 1'b1;
                rx_valid = ($urandom_range(0, 3) == 0);
                rx_data  = 8'($urandom);
                chk("tx_valid", 32'(tx_valid), 32'd1);
                chk("tx_data", 32'(tx_data), 32'(fr[k]));
                chk("rsp_quiet_send", 32'(rsp_valid), 32'd0);
                tick();
                if (tx_ready) k++;
            end
            chk("tx_count", 32'(k), 32'd6);
            tx_ready = 1'b1; rx_valid = 1'b0;
            chk("tx_done", 32'(tx_valid), 32'd0);

            if (no_rep) begin
                lat = 0;
                while (lat < T + 5 && !(rsp_valid || tx_valid)) begin
                    tick(); lat++;
                end
                chk("tmo_latency", 32'(lat), 32'(T + 1));
            end else begin
                for (int i = 0; i < 6; i++) begin
                    repeat ($urandom_range(0, 1)) begin
                        rx_valid = 1'b0; tick();
                        chk("rsp_quiet_rx", 32'(rsp_valid), 32'd0);
                    end
                    rx_valid = 1'b1; rx_data = rep[i];
                    tick();
                    rx_valid = 1'b0;
                    if (i < 5) chk("rsp_quiet_rx", 32'(rsp_valid), 32'd0);
                end
            end

            if (RETRY && att == 0 && (e == 3'd1 || e == 3'd2 || e == 3'd4)) begin
                chk("no_rsp_first_fail", 32'(rsp_valid), 32'd0);
            end else begin
                reported = 1'b1;
                chk("rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_err", 32'(rsp_err), 32'(e));
                chk("rsp_retried", 32'(rsp_retried), 32'(att));
                chk("req_ready_rsp", 32'(req_ready), 32'd1);
                if (!no_rep) begin
                    chk("rsp_status", 32'(rsp_status), 32'(rep[1]));
                    chk("rsp_addr", 32'(rsp_addr), 32'(rep[2]));
                    chk("rsp_data", 32'(rsp_data), 32'({rep[4], rep[3]}));
                end
                tick();
                chk("rsp_pulse", 32'(rsp_valid), 32'd0);
            end
        end
    endtask

    initial begin
        logic [7:0] cmd, addr, b0, b2, b5;
        logic [15:0] data;
        logic [5:0][7:0] rep;
        int mode;

        rst = 1'b1; req_valid = 1'b0; req_cmd = '0; req_addr = '0; req_data = '0;
        tx_ready = 1'b1; rx_valid = 1'b0; rx_data = '0;
        repeat (3) tick();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_fields", 32'({rsp_err, rsp_status, rsp_addr, rsp_retried}), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        rst = 1'b0;
        tick();

        // protocol examples
        run_txn(8'h03, 8'h00, 16'h0000, mk(8'h5A, 8'h00, 8'h01, 8'h16, 8'h00, 8'h4D), 1'b0, 1'b0);
        run_txn(8'h02, 8'h00, 16'h0000, mk(8'h5A, 8'h00, 8'h00, 8'h34, 8'h4B, 8'h25), 1'b0, 1'b0);
        run_txn(8'h02, 8'h00, 16'h0000, mk(8'h5A, 8'h00, 8'h00, 8'h34, 8'h4B, 8'h00), 1'b0, 1'b0);
        run_txn(8'h02, 8'h03, 16'h0000, mk(8'h5A, 8'h00, 8'h04, 8'h00, 8'h00, 8'h5E), 1'b0, 1'b0);
        run_txn(8'h02, 8'h07, 16'h0000, mk(8'h5A, 8'hE4, 8'h07, 8'h00, 8'h00, 8'hB9), 1'b0, 1'b1);
        run_txn(8'h02, 8'h11, 16'hBEEF, '0, 1'b1, 1'b1);

        // reset after the 3rd TX byte aborts the transaction
        chk("req_ready_pre_rst", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_cmd = 8'h02; req_addr = 8'h55; req_data = 16'h1234;
        tick();
        req_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_mid_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < T + 8; i++) begin
            tick();
            chk("rst_mid_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_txn(8'h03, 8'h20, 16'h00FF, mk(8'h5A, 8'h01, 8'h99, 8'h01, 8'h02, 8'h5A ^ 8'h01 ^ 8'h99 ^ 8'h01 ^ 8'h02), 1'b0, 1'b0);

        // randomized requests and replies
        for (int n = 0; n < 40; n++) begin
            cmd  = ($urandom_range(0, 1) == 1) ? 8'h02 : 8'h03;
            addr = 8'($urandom);
            data = 16'($urandom);
            mode = $urandom_range(0, 4);
            b0 = 8'h5A;
            b2 = addr;
            if (mode == 1) b0 = 8'h5A ^ 8'($urandom_range(1, 255));
            if (mode == 3) b2 = addr ^ 8'($urandom_range(1, 255));
            rep = mk(b0, 8'($urandom), b2, 8'($urandom), 8'($urandom), 8'h00);
            b5 = rep[0] ^ rep[1] ^ rep[2] ^ rep[3] ^ rep[4];
            if (mode == 2) b5 = b5 ^ 8'($urandom_range(1, 255));
            rep[5] = b5;
            run_txn(cmd, addr, data, rep, mode == 4, $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
